// File: rtl/controlador_display_7seg_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scan controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package pkg_7seg;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} estado_t;

    localparam int         N_DIGITOS   = 4;
    localparam logic [6:0] SEG_APAGADO = 7'h7F;

    localparam logic [6:0] TABLA_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/controlador_display_7seg_decodificador.sv
// Combinational hex-to-segment decoder; the controller registers its output.
module decodificador_hex_7seg
    import pkg_7seg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = TABLA_HEX[i_nibble];

endmodule

// File: rtl/controlador_display_7seg.sv
// Scan controller for a 4-digit multiplexed 7-segment display with per-slot
// blanking, leading-zero suppression and frame-aligned commit of new values.
//
// state | meaning
// IDLE  | display disabled, anodes off, prescaler and digit held at 0
// SHOW  | anode of the current digit driven low
// BLANK | anodes off at slot end, segments held to avoid ghosting
module controlador_display_7seg
    import pkg_7seg::*;
#(
    parameter int CLK_HZ    = 10_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int BLANK_CYC = 16
)(
    input  logic        clk_10MHz_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        we_i,
    input  logic [15:0] dato_i,
    input  logic [3:0]  punto_i,
    input  logic        blank_lz_i,
    output logic [3:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [1:0]  digito_o,
    output logic        busy_o
);

    localparam int            TICK     = CLK_HZ / SCAN_HZ;
    localparam int            PW       = $clog2(TICK);
    localparam logic [PW-1:0] FIN_SHOW = PW'(TICK - BLANK_CYC - 1);
    localparam logic [PW-1:0] FIN_SLOT = PW'(TICK - 1);
    localparam logic [PW-1:0] UNO      = PW'(1);

    estado_t       r_estado, w_estado_sig;
    logic [PW-1:0] r_presc, w_presc_sig;
    logic [1:0]    r_digito, w_digito_sig;
    logic [15:0]   r_sombra_dato, r_disp_dato, w_disp_dato_sig;
    logic [3:0]    r_sombra_punto, r_disp_punto, w_disp_punto_sig;
    logic          r_pendiente;
    logic          w_commit;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_dec;
    logic          w_suprimir;
    logic [3:0]    w_an_sig;
    logic [6:0]    w_seg_sig;
    logic          w_dp_sig;

    always_comb begin
        w_estado_sig = r_estado;
        w_presc_sig  = r_presc;
        w_digito_sig = r_digito;
        w_commit     = 1'b0;
        if (!en_i) begin
            w_estado_sig = IDLE;
            w_presc_sig  = '0;
            w_digito_sig = '0;
        end else begin
            case (r_estado)
                IDLE: begin
                    w_estado_sig = SHOW;
                    w_presc_sig  = '0;
                    w_digito_sig = '0;
                    w_commit     = 1'b1;
                end
                SHOW: begin
                    w_presc_sig = r_presc + UNO;
                    if (r_presc == FIN_SHOW) w_estado_sig = BLANK;
                end
                BLANK: begin
                    if (r_presc == FIN_SLOT) begin
                        w_estado_sig = SHOW;
                        w_presc_sig  = '0;
                        w_digito_sig = r_digito + 2'd1;
                        w_commit     = (r_digito == 2'd3);
                    end else begin
                        w_presc_sig = r_presc + UNO;
                    end
                end
                default: begin
                    w_estado_sig = IDLE;
                    w_presc_sig  = '0;
                    w_digito_sig = '0;
                end
            endcase
        end
    end

    // Outputs are computed from next-cycle state so they register on the same edge.
    assign w_disp_dato_sig  = w_commit ? r_sombra_dato  : r_disp_dato;
    assign w_disp_punto_sig = w_commit ? r_sombra_punto : r_disp_punto;

    always_comb begin
        w_nibble   = w_disp_dato_sig[3:0];
        w_suprimir = 1'b0;
        case (w_digito_sig)
            2'd3: begin
                w_nibble   = w_disp_dato_sig[15:12];
                w_suprimir = (w_disp_dato_sig[15:12] == 4'h0);
            end
            2'd2: begin
                w_nibble   = w_disp_dato_sig[11:8];
                w_suprimir = (w_disp_dato_sig[15:8] == 8'h00);
            end
            2'd1: begin
                w_nibble   = w_disp_dato_sig[7:4];
                w_suprimir = (w_disp_dato_sig[15:4] == 12'h000);
            end
            default: begin
                w_nibble   = w_disp_dato_sig[3:0];
                w_suprimir = 1'b0;
            end
        endcase
    end

    decodificador_hex_7seg u_decodificador (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    always_comb begin
        w_an_sig  = 4'hF;
        w_seg_sig = SEG_APAGADO;
        w_dp_sig  = 1'b1;
        case (w_estado_sig)
            SHOW: begin
                w_an_sig  = ~(4'b0001 << w_digito_sig);
                w_seg_sig = (blank_lz_i && w_suprimir) ? SEG_APAGADO : w_seg_dec;
                w_dp_sig  = ~w_disp_punto_sig[w_digito_sig];
            end
            BLANK: begin
                w_seg_sig = seg_o;
                w_dp_sig  = ~w_disp_punto_sig[w_digito_sig];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_10MHz_i or negedge rst_i) begin
        if (!rst_i) begin
            r_estado       <= IDLE;
            r_presc        <= '0;
            r_digito       <= '0;
            r_sombra_dato  <= '0;
            r_sombra_punto <= '0;
            r_disp_dato    <= '0;
            r_disp_punto   <= '0;
            r_pendiente    <= 1'b0;
            an_o           <= 4'hF;
            seg_o          <= SEG_APAGADO;
            dp_o           <= 1'b1;
        end else begin
            r_estado <= w_estado_sig;
            r_presc  <= w_presc_sig;
            r_digito <= w_digito_sig;
            if (w_commit) begin
                r_disp_dato  <= r_sombra_dato;
                r_disp_punto <= r_sombra_punto;
            end
            // A write on the commit edge lands in the shadow and stays pending.
            if (we_i) begin
                r_sombra_dato  <= dato_i;
                r_sombra_punto <= punto_i;
                r_pendiente    <= 1'b1;
            end else if (w_commit) begin
                r_pendiente <= 1'b0;
            end
            an_o  <= w_an_sig;
            seg_o <= w_seg_sig;
            dp_o  <= w_dp_sig;
        end
    end

    assign digito_o = r_digito;
    assign busy_o   = r_pendiente;

endmodule

// File: tb/tb_controlador_display_7seg.sv
// Directed bench for the 7-segment scan controller with TICK=10, BLANK_CYC=2.
module tb_controlador_display_7seg;

    logic        clk_10MHz_i;
    logic        rst_i;
    logic        en_i;
    logic        we_i;
    logic [15:0] dato_i;
    logic [3:0]  punto_i;
    logic        blank_lz_i;
    logic [3:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [1:0]  digito_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    controlador_display_7seg #(
        .CLK_HZ    (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (2)
    ) dut (
        .clk_10MHz_i (clk_10MHz_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .we_i        (we_i),
        .dato_i      (dato_i),
        .punto_i     (punto_i),
        .blank_lz_i  (blank_lz_i),
        .an_o        (an_o),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .digito_o    (digito_o),
        .busy_o      (busy_o)
    );

    initial clk_10MHz_i = 1'b0;
    always #5 clk_10MHz_i = ~clk_10MHz_i;

    task automatic step();
        @(posedge clk_10MHz_i);
        #1;
    endtask

    // Advance to the first sample of the next slot of digit d.
    task automatic wait_slot_start(input logic [1:0] d);
        logic [1:0] prev;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            prev = digito_o;
            step();
            if (digito_o == d && prev != d) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_slot: digito_o=%0d never entered slot %0d within 60 cycles", digito_o, d);
        end
    endtask

    task automatic write_val(input logic [15:0] v, input logic [3:0] p);
        dato_i  = v;
        punto_i = p;
        we_i    = 1'b1;
        step();
        we_i    = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b0;
        repeat (3) step();
        checks++; if (an_o !== 4'hF)    begin errors++; $display("FAIL reset_an: got %h required f", an_o); end
        checks++; if (seg_o !== 7'h7F)  begin errors++; $display("FAIL reset_seg: got %h required 7f", seg_o); end
        checks++; if (dp_o !== 1'b1)    begin errors++; $display("FAIL reset_dp: got %b required 1", dp_o); end
        checks++; if (digito_o !== 2'd0) begin errors++; $display("FAIL reset_digito: got %0d required 0", digito_o); end
        checks++; if (busy_o !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        rst_i = 1'b1;
        step();
        checks++; if (an_o !== 4'hF)    begin errors++; $display("FAIL idle_an: got %h required f", an_o); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        en_i = 1'b1;
        step();
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 10; c++) begin
                exp_an = 4'hF;
                if (c < 8) exp_an[d] = 1'b0;
                checks++; if (an_o !== exp_an) begin errors++; $display("FAIL scan_an d%0d c%0d: got %b required %b", d, c, an_o, exp_an); end
                checks++; if (seg_o !== 7'h40) begin errors++; $display("FAIL scan_seg d%0d c%0d: got %h required 40", d, c, seg_o); end
                checks++; if (digito_o !== 2'(d)) begin errors++; $display("FAIL scan_digito d%0d c%0d: got %0d", d, c, digito_o); end
                checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL scan_dp d%0d c%0d: got %b required 1", d, c, dp_o); end
                step();
            end
        end
        checks++; if (an_o !== 4'b1110) begin errors++; $display("FAIL scan_wrap_an: got %b required 1110", an_o); end
    endtask

    task automatic test_write();
        write_val(16'h12AF, 4'b0100);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy_set: got %b required 1", busy_o); end
        checks++; if (seg_o !== 7'h40) begin errors++; $display("FAIL wr_old_d0: got %h required 40", seg_o); end
        wait_slot_start(2'd3);
        checks++; if (seg_o !== 7'h40) begin errors++; $display("FAIL wr_old_d3: got %h required 40", seg_o); end
        checks++; if (an_o !== 4'b0111) begin errors++; $display("FAIL wr_an_d3: got %b required 0111", an_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy_d3: got %b required 1", busy_o); end
        wait_slot_start(2'd0);
        checks++; if (seg_o !== 7'h0E) begin errors++; $display("FAIL wr_new_d0: got %h required 0e", seg_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_clr: got %b required 0", busy_o); end
        checks++; if (an_o !== 4'b1110) begin errors++; $display("FAIL wr_an_d0: got %b required 1110", an_o); end
        wait_slot_start(2'd1);
        checks++; if (seg_o !== 7'h08) begin errors++; $display("FAIL wr_new_d1: got %h required 08", seg_o); end
        wait_slot_start(2'd2);
        checks++; if (seg_o !== 7'h24) begin errors++; $display("FAIL wr_new_d2: got %h required 24", seg_o); end
        checks++; if (dp_o !== 1'b0)   begin errors++; $display("FAIL wr_dp_d2: got %b required 0", dp_o); end
        wait_slot_start(2'd3);
        checks++; if (seg_o !== 7'h79) begin errors++; $display("FAIL wr_new_d3: got %h required 79", seg_o); end
        checks++; if (dp_o !== 1'b1)   begin errors++; $display("FAIL wr_dp_d3: got %b required 1", dp_o); end
    endtask

    task automatic test_leading_zero();
        blank_lz_i = 1'b1;
        write_val(16'h0050, 4'b0000);
        wait_slot_start(2'd0);
        checks++; if (seg_o !== 7'h40) begin errors++; $display("FAIL lz50_d0: got %h required 40", seg_o); end
        wait_slot_start(2'd1);
        checks++; if (seg_o !== 7'h12) begin errors++; $display("FAIL lz50_d1: got %h required 12", seg_o); end
        checks++; if (an_o !== 4'b1101) begin errors++; $display("FAIL lz50_an_d1: got %b required 1101", an_o); end
        wait_slot_start(2'd2);
        checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL lz50_d2: got %h required 7f", seg_o); end
        wait_slot_start(2'd3);
        checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL lz50_d3: got %h required 7f", seg_o); end
        checks++; if (an_o !== 4'b0111) begin errors++; $display("FAIL lz50_an_d3: got %b required 0111", an_o); end
        write_val(16'h0000, 4'b0000);
        wait_slot_start(2'd0);
        checks++; if (seg_o !== 7'h40) begin errors++; $display("FAIL lz0_d0: got %h required 40", seg_o); end
        wait_slot_start(2'd1);
        checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL lz0_d1: got %h required 7f", seg_o); end
        wait_slot_start(2'd2);
        checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL lz0_d2: got %h required 7f", seg_o); end
        wait_slot_start(2'd3);
        checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL lz0_d3: got %h required 7f", seg_o); end
        blank_lz_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        wait_slot_start(2'd0);
        write_val(16'h1111, 4'b0000);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy1: got %b required 1", busy_o); end
        wait_slot_start(2'd1);
        write_val(16'h2222, 4'b0000);
        wait_slot_start(2'd3);
        repeat (8) step();
        checks++; if (an_o !== 4'hF)    begin errors++; $display("FAIL b2b_blank_an: got %b required 1111", an_o); end
        checks++; if (seg_o !== 7'h40)  begin errors++; $display("FAIL b2b_blank_seg: got %h required 40", seg_o); end
        checks++; if (digito_o !== 2'd3) begin errors++; $display("FAIL b2b_blank_digito: got %0d required 3", digito_o); end
        step();
        write_val(16'h3333, 4'b0000);
        checks++; if (digito_o !== 2'd0) begin errors++; $display("FAIL b2b_commit_digito: got %0d required 0", digito_o); end
        checks++; if (seg_o !== 7'h24)  begin errors++; $display("FAIL b2b_commit_d0: got %h required 24", seg_o); end
        checks++; if (busy_o !== 1'b1)  begin errors++; $display("FAIL b2b_busy_held: got %b required 1", busy_o); end
        wait_slot_start(2'd1);
        checks++; if (seg_o !== 7'h24)  begin errors++; $display("FAIL b2b_d1: got %h required 24", seg_o); end
        wait_slot_start(2'd2);
        checks++; if (seg_o !== 7'h24)  begin errors++; $display("FAIL b2b_d2: got %h required 24", seg_o); end
        wait_slot_start(2'd3);
        checks++; if (seg_o !== 7'h24)  begin errors++; $display("FAIL b2b_d3: got %h required 24", seg_o); end
        checks++; if (busy_o !== 1'b1)  begin errors++; $display("FAIL b2b_busy_d3: got %b required 1", busy_o); end
        wait_slot_start(2'd0);
        checks++; if (seg_o !== 7'h30)  begin errors++; $display("FAIL b2b_third_d0: got %h required 30", seg_o); end
        checks++; if (busy_o !== 1'b0)  begin errors++; $display("FAIL b2b_busy_clr: got %b required 0", busy_o); end
    endtask

    task automatic test_disable();
        wait_slot_start(2'd2);
        repeat (3) step();
        en_i = 1'b0;
        step();
        checks++; if (an_o !== 4'hF)     begin errors++; $display("FAIL dis_an: got %b required 1111", an_o); end
        checks++; if (digito_o !== 2'd0) begin errors++; $display("FAIL dis_digito: got %0d required 0", digito_o); end
        checks++; if (seg_o !== 7'h7F)   begin errors++; $display("FAIL dis_seg: got %h required 7f", seg_o); end
        checks++; if (dp_o !== 1'b1)     begin errors++; $display("FAIL dis_dp: got %b required 1", dp_o); end
        repeat (3) step();
        checks++; if (an_o !== 4'hF)     begin errors++; $display("FAIL dis_hold_an: got %b required 1111", an_o); end
        en_i = 1'b1;
        step();
        checks++; if (digito_o !== 2'd0) begin errors++; $display("FAIL ren_digito: got %0d required 0", digito_o); end
        checks++; if (seg_o !== 7'h30)   begin errors++; $display("FAIL ren_seg: got %h required 30", seg_o); end
        for (int c = 0; c < 8; c++) begin
            checks++; if (an_o !== 4'b1110) begin errors++; $display("FAIL ren_show c%0d: got %b required 1110", c, an_o); end
            step();
        end
        checks++; if (an_o !== 4'hF)     begin errors++; $display("FAIL ren_blank: got %b required 1111", an_o); end
    endtask

    task automatic test_async_reset();
        write_val(16'h5555, 4'b1111);
        checks++; if (busy_o !== 1'b1)   begin errors++; $display("FAIL ar_busy_pre: got %b required 1", busy_o); end
        #3 rst_i = 1'b0;
        #1;
        checks++; if (an_o !== 4'hF)     begin errors++; $display("FAIL ar_an: got %b required 1111", an_o); end
        checks++; if (seg_o !== 7'h7F)   begin errors++; $display("FAIL ar_seg: got %h required 7f", seg_o); end
        checks++; if (dp_o !== 1'b1)     begin errors++; $display("FAIL ar_dp: got %b required 1", dp_o); end
        checks++; if (digito_o !== 2'd0) begin errors++; $display("FAIL ar_digito: got %0d required 0", digito_o); end
        checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL ar_busy: got %b required 0", busy_o); end
        #2 rst_i = 1'b1;
        step();
        checks++; if (an_o !== 4'b1110)  begin errors++; $display("FAIL ar_post_an: got %b required 1110", an_o); end
        checks++; if (seg_o !== 7'h40)   begin errors++; $display("FAIL ar_post_d0: got %h required 40", seg_o); end
        checks++; if (dp_o !== 1'b1)     begin errors++; $display("FAIL ar_post_dp: got %b required 1", dp_o); end
        wait_slot_start(2'd1);
        checks++; if (seg_o !== 7'h40)   begin errors++; $display("FAIL ar_post_d1: got %h required 40", seg_o); end
        wait_slot_start(2'd2);
        checks++; if (seg_o !== 7'h40)   begin errors++; $display("FAIL ar_post_d2: got %h required 40", seg_o); end
        wait_slot_start(2'd3);
        checks++; if (seg_o !== 7'h40)   begin errors++; $display("FAIL ar_post_d3: got %h required 40", seg_o); end
        checks++; if (busy_o !== 1'b0)   begin errors++; $display("FAIL ar_post_busy: got %b required 0", busy_o); end
    endtask

    initial begin
        rst_i      = 1'b1;
        en_i       = 1'b0;
        we_i       = 1'b0;
        dato_i     = 16'h0000;
        punto_i    = 4'h0;
        blank_lz_i = 1'b0;
        test_reset();
        test_scan();
        test_write();
        test_leading_zero();
        test_back_to_back();
        test_disable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
